// File: rtl/branch_cmp_pipe.sv
// branch_cmp_pipe: two-stage branch-condition compare pipeline (valid/ready), optional saturating stats under BRANCH_CMP_STAT_EN
module branch_cmp_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  cmpA,
  input  logic [WIDTH-1:0]  cmpB,
  input  logic [2:0]        cmpOp,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              cmpOut,
  output logic [STAT_W-1:0] stat_total,
  output logic [STAT_W-1:0] stat_taken
);
  logic             s1Valid, s2Valid, s2Out, s1Adv, accept, cmpRes, aNeg, aZero;
  logic [WIDTH-1:0] s1A, s1B;
  logic [2:0]       s1Op;
  assign s1Adv     = s1Valid && (!s2Valid || out_ready) && !flush;
  assign in_ready  = !flush && (!s1Valid || s1Adv);
  assign accept    = in_valid && in_ready;
  assign out_valid = s2Valid;
  assign cmpOut    = s2Valid && s2Out;
  assign aNeg      = s1A[WIDTH-1];
  assign aZero     = s1A == '0;
  always_comb begin
    cmpRes = s1Op == 3'd0 ? s1A == s1B :
             s1Op == 3'd1 ? s1A != s1B :
             s1Op == 3'd2 ? aNeg || aZero :
             s1Op == 3'd3 ? !aNeg && !aZero :
             s1Op == 3'd4 ? aNeg :
             s1Op == 3'd5 ? !aNeg :
             s1Op == 3'd6 ? $signed(s1A) < $signed(s1B) :
                            s1A < s1B;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1Valid <= 1'b0;
      s2Valid <= 1'b0;
    end else begin
      s1Valid <= !flush && (accept || (s1Valid && !s1Adv));
      s2Valid <= !flush && (s1Adv || (s2Valid && !out_ready));
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      s1A  <= cmpA;
      s1B  <= cmpB;
      s1Op <= cmpOp;
    end
    if (s1Adv) s2Out <= cmpRes;
  end
`ifdef BRANCH_CMP_STAT_EN
  logic              consume;
  logic [STAT_W-1:0] total, taken;
  assign consume = s2Valid && out_ready && !flush;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total <= '0;
      taken <= '0;
    end else begin
      if (consume && !(&total)) total <= total + STAT_W'(1);
      if (consume && s2Out && !(&taken)) taken <= taken + STAT_W'(1);
    end
  end
  assign stat_total = total;
  assign stat_taken = taken;
`else
  assign stat_total = '0;
  assign stat_taken = '0;
`endif
endmodule

// File: tb/tb_branch_cmp_pipe.sv
// tb_branch_cmp_pipe: directed self-checking bench for branch_cmp_pipe
module tb_branch_cmp_pipe;
  localparam int W  = 32;
  localparam int SW = 4;
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic          flush = 1'b0;
  logic [W-1:0]  cmpA = '0;
  logic [W-1:0]  cmpB = '0;
  logic [2:0]    cmpOp = '0;
  logic          in_ready, out_valid, cmpOut;
  logic [SW-1:0] stat_total, stat_taken;
  int nTests = 0;
  int nFail = 0;
  int expTotal = 0;
  int expTaken = 0;
  int idx, got, cnt;
  logic [2:0]   tOp[19] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4,
                            3'd4, 3'd5, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd6, 3'd7};
  logic [W-1:0] tA[19]  = '{32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h0, 32'h0,
                            32'h8000_0000, 32'h5, 32'h0, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
                            32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'h1, 32'h1, 32'h5, 32'h5};
  logic [W-1:0] tB[19]  = '{32'h1234_5678, 32'h1234_5679, 32'h1234_5678, 32'h8000_0000,
                            32'hFFFF_FFFF, 32'h0, 32'h0, 32'h1, 32'h0, 32'h1,
                            32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h1, 32'h1,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5, 32'h5};
  logic         tE[19]  = '{1, 0, 0, 1, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0};
  logic [2:0]   bOp[4] = '{3'd0, 3'd1, 3'd7, 3'd6};
  logic [W-1:0] bA[4]  = '{32'h5, 32'h5, 32'h0, 32'h5};
  logic [W-1:0] bB[4]  = '{32'h5, 32'h5, 32'h1, 32'h3};
  logic         bE[4]  = '{1, 0, 1, 0};

  branch_cmp_pipe #(.WIDTH(W), .STAT_W(SW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .cmpA(cmpA), .cmpB(cmpB), .cmpOp(cmpOp), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .cmpOut(cmpOut),
    .stat_total(stat_total), .stat_taken(stat_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic countRes(input logic t);
    if (expTotal < 15) expTotal++;
    if (t && expTaken < 15) expTaken++;
  endtask

  task automatic chkStats(input string tag);
`ifdef BRANCH_CMP_STAT_EN
    chk({tag, "_total"}, stat_total, expTotal);
    chk({tag, "_taken"}, stat_taken, expTaken);
`else
    chk({tag, "_total"}, stat_total, 0);
    chk({tag, "_taken"}, stat_taken, 0);
`endif
  endtask

  task automatic single(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic e);
    cmpOp = op; cmpA = a; cmpB = b; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, in_ready, 1);
    step;
    in_valid = 1'b0; cmpOp = ~op; cmpA = ~a; cmpB = ~b;
    #1;
    chk({tag, "_lat1"}, out_valid, 0);
    step;
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_out"}, cmpOut, e);
    countRes(e);
    step;
    chk({tag, "_done"}, out_valid, 0);
  endtask

  initial begin
    #1;
    chk("rst_vld", out_valid, 0);
    chk("rst_out", cmpOut, 0);
    chkStats("rst");
    step;
    step;
    reset = 1'b1;
    #1;
    chk("rel_rdy", in_ready, 1);

    for (int i = 0; i < 19; i++) single($sformatf("op%0d", i), tOp[i], tA[i], tB[i], tE[i]);
    chkStats("ops");

    idx = 0; got = 0;
    for (int c = 0; c < 14; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      in_valid = idx < 4;
      if (idx < 4) begin
        cmpOp = bOp[idx]; cmpA = bA[idx]; cmpB = bB[idx];
      end
      #1;
      if (c <= 6) chk($sformatf("b2b_rdy%0d", c), in_ready, !(c >= 2 && c <= 4));
      if (c >= 2 && c <= 4) begin
        chk($sformatf("b2b_hold_vld%0d", c), out_valid, 1);
        chk($sformatf("b2b_hold_out%0d", c), cmpOut, 1);
      end
      if (out_valid && out_ready) begin
        if (got < 4) begin
          chk($sformatf("b2b_res%0d", got), cmpOut, bE[got]);
          countRes(bE[got]);
        end else chk("b2b_extra", out_valid, 0);
        got++;
      end
      if (in_valid && in_ready) idx++;
      step;
    end
    in_valid = 1'b0;
    chk("b2b_accepted", idx, 4);
    chk("b2b_delivered", got, 4);
    chkStats("b2b");

    out_ready = 1'b0; in_valid = 1'b1; cmpOp = 3'd0; cmpA = 32'h7; cmpB = 32'h7;
    #1;
    chk("fl_rdy0", in_ready, 1);
    step;
    cmpA = 32'h9; cmpB = 32'h9;
    #1;
    chk("fl_rdy1", in_ready, 1);
    step;
    in_valid = 1'b0;
    #1;
    chk("fl_full_rdy", in_ready, 0);
    chk("fl_full_vld", out_valid, 1);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("fl_rdy", in_ready, 0);
    step;
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl_vld0", out_valid, 0);
    chkStats("fl");
    step;
    chk("fl_vld1", out_valid, 0);
    step;
    chk("fl_vld2", out_valid, 0);
    chkStats("fl_after");

    out_ready = 1'b1; in_valid = 1'b1; cmpOp = 3'd0; cmpA = 32'h1; cmpB = 32'h1;
    step;
    cmpOp = 3'd1; cmpB = 32'h2;
    step;
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("ar_pre_vld", out_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_vld", out_valid, 0);
    chk("ar_out", cmpOut, 0);
    expTotal = 0; expTaken = 0;
    chkStats("ar");
    step;
    step;
    chk("ar_hold_vld", out_valid, 0);
    reset = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("ar_rel_vld", out_valid, 0);
    single("ar_next", 3'd3, 32'h1, 32'h0, 1'b1);

    cnt = 0;
    for (int c = 0; c < 26; c++) begin
      in_valid = c < 20; cmpOp = 3'd0; cmpA = c; cmpB = c; out_ready = 1'b1;
      #1;
      if (c < 20) chk($sformatf("sat_rdy%0d", c), in_ready, 1);
      if (out_valid) begin
        chk($sformatf("sat_out%0d", cnt), cmpOut, 1);
        countRes(1'b1);
        cnt++;
      end
      step;
    end
    in_valid = 1'b0;
    chk("sat_count", cnt, 20);
    chkStats("sat");
    step;
    step;
    chkStats("sat_held");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/branch_cmp_pipe.md
BRANCH_CMP_PIPE -- requirements
Module: branch_cmp_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits, legal range 8..64.
REQ-002 SHALL have parameter STAT_W, default 16: width of each statistics counter.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port in_valid, input, 1: request present on cmpA/cmpB/cmpOp.
REQ-006 SHALL have port in_ready, output, 1: request accepted on the edge where in_valid && in_ready.
REQ-007 SHALL have port cmpA, input, WIDTH: first operand.
REQ-008 SHALL have port cmpB, input, WIDTH: second operand.
REQ-009 SHALL have port cmpOp, input, 3: comparison select.
REQ-010 SHALL have port flush, input, 1: synchronous kill of all in-flight requests.
REQ-011 SHALL have port out_valid, output, 1: a result is present on cmpOut.
REQ-012 SHALL have port out_ready, input, 1: consumer takes the result on the edge where out_valid && out_ready.
REQ-013 SHALL have port cmpOut, output, 1: branch condition true.
REQ-014 SHALL have port stat_total, output, STAT_W: count of results consumed.
REQ-015 SHALL have port stat_taken, output, STAT_W: count of consumed results with cmpOut=1.

Function
REQ-016 SHALL decode cmpOp: 000 A==B; 001 A!=B; 010 A<=0 signed; 011 A>0 signed; 100 A<0 signed; 101 A>=0 signed; 110 A<B signed; 111 A<B unsigned.
REQ-017 SHALL ignore cmpB for ops 010..101.
REQ-018 SHALL be a two-stage pipeline: S1 registers operands and op; S2 registers the computed cmpOut. Each stage holds one valid bit.
REQ-019 SHALL present a result on out_valid exactly 2 cycles after acceptance when out_ready stays 1.
REQ-020 SHALL sustain one accepted request per cycle when out_ready stays 1.
REQ-021 SHALL hold S2 (out_valid, cmpOut) stable while out_valid && !out_ready.
REQ-022 SHALL advance S1 into S2 when S2 is empty or being consumed in the same cycle.
REQ-023 SHALL drive in_ready = !S1.valid || S1 advancing, combinationally. No request is dropped and none is duplicated.
REQ-024 SHALL, on flush=1, clear both valid bits at the next edge, ignore in_valid that cycle, and drive in_ready=0 that cycle.
REQ-025 SHALL give flush priority over a simultaneous accept or consume. A result killed by flush is not counted as consumed.
REQ-026 SHALL leave the data registers unchanged when their valid bit is 0. Only valid bits are reset.

Reset
REQ-027 SHALL, while reset=0, force S1.valid=0, S2.valid=0, out_valid=0, cmpOut=0, stat_total=0 and stat_taken=0, independent of clk.
REQ-028 SHALL discard in-flight requests when reset asserts mid-operation. The first accept is possible on the first edge after release.
REQ-029 SHALL drive in_ready=1 on the first cycle after reset release.

Configuration
REQ-030 SHALL implement the statistics counters only when macro BRANCH_CMP_STAT_EN is defined.
REQ-031 SHALL, with BRANCH_CMP_STAT_EN defined, increment stat_total on each consume and stat_taken on each consume with cmpOut=1. Both counters saturate at all-ones and never wrap.
REQ-032 SHALL, without BRANCH_CMP_STAT_EN, tie stat_total and stat_taken to 0 and contain no counter flops.

Verification
REQ-033 SHALL cover: op 000, A=B=32'h1234_5678, out_ready=1 -> out_valid=1 with cmpOut=1 exactly 2 cycles after accept.
REQ-034 SHALL cover signed/unsigned split: A=32'hFFFF_FFFF, B=1; op 110 -> cmpOut=1; op 111 -> cmpOut=0; op 100 -> cmpOut=1; op 011 with A=0 -> cmpOut=0.
REQ-035 SHALL cover back-to-back: 4 requests on consecutive cycles, out_ready low for 3 cycles at request 2 -> in_ready=0 once both stages are full, S2 held stable, all 4 results delivered in order with none lost.
REQ-036 SHALL cover flush with both stages valid and out_ready=0 -> out_valid=0 next cycle, no result emitted, stat_total unchanged.
REQ-037 SHALL cover asynchronous reset pulled low mid-clock with 2 requests in flight -> out_valid=0 immediately; after release the next request completes in 2 cycles.
REQ-038 SHALL cover, with BRANCH_CMP_STAT_EN and STAT_W=4: 20 taken results -> stat_total=stat_taken=4'hF, held. Without the macro both read 0.
